// File: rtl/two_of_five_deser.sv
// Serial 2-of-5 receiver: shifts 5 bits MSB first, decodes to BCD, one-entry valid/ready buffer.
// Define TWO_OF_FIVE_ERRCNT_EN to build the saturating err_count register.
module two_of_five_deser (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sync,
  input  logic       bit_valid,
  input  logic       ser_in,
  output logic [3:0] digit,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       code_err,
  output logic       overrun,
  output logic [7:0] err_count
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t     state, state_nx;
  logic [3:0] shreg;
  logic [2:0] bcnt;
  logic [4:0] code;
  logic       done;
  logic       ok;
  logic [3:0] dec;
  logic [3:0] digit_nx;
  logic       ovr_nx;

  assign code = {shreg, ser_in};
  // sync wins over completion, so a sync on the 5th bit starts a new symbol
  assign done = bit_valid && !sync && (bcnt == 3'd4);

  always_comb begin
    ok  = 1'b1;
    dec = 4'd0;
    case (code)
      5'b00011: dec = 4'd0;
      5'b00101: dec = 4'd1;
      5'b00110: dec = 4'd2;
      5'b01001: dec = 4'd3;
      5'b01010: dec = 4'd4;
      5'b01100: dec = 4'd5;
      5'b10001: dec = 4'd6;
      5'b10010: dec = 4'd7;
      5'b10100: dec = 4'd8;
      5'b11000: dec = 4'd9;
      default:  ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= 4'd0;
      bcnt  <= 3'd0;
    end else if (bit_valid) begin
      if (sync) begin
        shreg <= {3'd0, ser_in};
        bcnt  <= 3'd1;
      end else if (bcnt == 3'd4) begin
        shreg <= 4'd0;
        bcnt  <= 3'd0;
      end else begin
        shreg <= {shreg[2:0], ser_in};
        bcnt  <= bcnt + 3'd1;
      end
    end else if (sync) begin
      shreg <= 4'd0;
      bcnt  <= 3'd0;
    end
  end

  always_comb begin
    state_nx = state;
    digit_nx = digit;
    ovr_nx   = 1'b0;
    unique case (state)
      EMPTY: begin
        if (done && ok) begin
          state_nx = FULL;
          digit_nx = dec;
        end
      end
      FULL: begin
        if (done && ok) begin
          if (out_ready) digit_nx = dec;
          else           ovr_nx   = 1'b1;
        end else if (out_ready) begin
          state_nx = EMPTY;
        end
      end
      default: state_nx = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      digit    <= 4'd0;
      code_err <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_nx;
      digit    <= digit_nx;
      code_err <= done && !ok;
      overrun  <= ovr_nx;
    end
  end

  assign out_valid = (state == FULL);

`ifdef TWO_OF_FIVE_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= 8'd0;
    end else if (done && !ok && err_count != 8'hff) begin
      err_count <= err_count + 8'd1;
    end
  end
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_two_of_five_deser.sv
// Scoreboard bench for two_of_five_deser: stimulus pushes expected digits,
// a negedge monitor pops them on each out_valid && out_ready handshake.
module tb_two_of_five_deser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sync = 1'b0;
  logic       bit_valid = 1'b0;
  logic       ser_in = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] digit;
  logic       out_valid;
  logic       code_err;
  logic       overrun;
  logic [7:0] err_count;

  int passed = 0;
  int total = 0;
  int err_seen = 0;
  int ovr_seen = 0;
  int e0, o0;
  logic [3:0] exp_q[$];

`ifdef TWO_OF_FIVE_ERRCNT_EN
  localparam int CNT_EN = 1;
`else
  localparam int CNT_EN = 0;
`endif

  two_of_five_deser dut (
    .clk(clk),
    .rst_n(rst_n),
    .sync(sync),
    .bit_valid(bit_valid),
    .ser_in(ser_in),
    .digit(digit),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .code_err(code_err),
    .overrun(overrun),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (code_err) begin
        err_seen++;
        chk("err_ovr_exclusive", int'(overrun), 0);
      end
      if (overrun) ovr_seen++;
      if (out_valid && out_ready) begin
        chk("pop_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("digit", int'(digit), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic send_bits(input logic [4:0] c, input int n);
    for (int i = 4; i > 4 - n; i--) begin
      @(posedge clk);
      #1;
      sync = 1'b0;
      bit_valid = 1'b1;
      ser_in = c[i];
    end
  endtask

  task automatic send_sym(input logic [4:0] c);
    send_bits(c, 5);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bit_valid = 1'b0;
      sync = 1'b0;
    end
  endtask

  initial begin
    logic [4:0] codes [10];
    codes = '{5'b00011, 5'b00101, 5'b00110, 5'b01001, 5'b01010,
              5'b01100, 5'b10001, 5'b10010, 5'b10100, 5'b11000};

    #12;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_digit", int'(digit), 0);
    chk("rst_code_err", int'(code_err), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_err_count", int'(err_count), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // all ten codes back-to-back, consumer always ready
    out_ready = 1'b1;
    e0 = err_seen; o0 = ovr_seen;
    for (int d = 0; d < 10; d++) begin
      exp_q.push_back(4'(d));
      send_sym(codes[d]);
    end
    idle(3);
    chk("t1_drained", exp_q.size(), 0);
    chk("t1_code_err", err_seen - e0, 0);
    chk("t1_overrun", ovr_seen - o0, 0);

    // invalid symbols
    e0 = err_seen;
    send_sym(5'b00111);
    send_sym(5'b00000);
    idle(3);
    chk("t2_code_err", err_seen - e0, 2);
    chk("t2_out_valid", int'(out_valid), 0);
    chk("t2_err_count", int'(err_count), CNT_EN ? 2 : 0);

    // overrun while held
    out_ready = 1'b0;
    o0 = ovr_seen;
    exp_q.push_back(4'd4);
    send_sym(5'b01010);
    send_sym(5'b11000);
    idle(3);
    chk("t3_overrun", ovr_seen - o0, 1);
    chk("t3_out_valid", int'(out_valid), 1);
    chk("t3_digit_held", int'(digit), 4);
    out_ready = 1'b1;
    idle(3);
    chk("t3_drained", exp_q.size(), 0);
    chk("t3_empty", int'(out_valid), 0);

    // sync discards a partial symbol
    e0 = err_seen;
    send_bits(5'b10001, 3);
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
    sync = 1'b1;
    exp_q.push_back(4'd7);
    send_sym(5'b10010);
    idle(3);
    chk("t4_drained", exp_q.size(), 0);
    chk("t4_code_err", err_seen - e0, 0);

    // asynchronous reset mid-symbol with a buffered digit
    out_ready = 1'b0;
    send_sym(5'b01100);
    send_bits(5'b10001, 2);
    #2;
    chk("t5_pre_valid", int'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", int'(out_valid), 0);
    chk("t5_rst_digit", int'(digit), 0);
    chk("t5_rst_code_err", int'(code_err), 0);
    chk("t5_rst_overrun", int'(overrun), 0);
    chk("t5_rst_err_count", int'(err_count), 0);
    bit_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    exp_q.push_back(4'd5);
    send_sym(5'b01100);
    idle(3);
    chk("t5_drained", exp_q.size(), 0);

    if (CNT_EN != 0) begin
      e0 = err_seen;
      repeat (260) send_sym(5'b00000);
      idle(3);
      chk("t6_code_err", err_seen - e0, 260);
      chk("t6_err_count_sat", int'(err_count), 255);
    end

    chk("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
